// File: rtl/axil_reg_arbiter.sv
// axil_reg_arbiter: round-robin arbiter that shares one AXI4-Lite master port
// between two hold-until-ack register requesters, one transaction at a time.
module axil_reg_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [1:0]                    req,
  input  logic [1:0]                    req_we,
  input  logic [2*C_ADDR_WIDTH-1:0]     req_addr,
  input  logic [2*C_DATA_WIDTH-1:0]     req_wdata,
  input  logic [2*C_DATA_WIDTH/8-1:0]   req_wstrb,
  output logic [1:0]                    ack,
  output logic [C_DATA_WIDTH-1:0]       rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0]     m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);
  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;
  localparam int SW = C_DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t          state;
  logic            grant, last_grant, nxt, sel_we, aw_done, w_done;
  logic [AW-1:0]   addr, sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;
  // On contention the requester that did not win last time gets the grant.
  assign nxt       = &req ? ~last_grant : req[1];
  assign sel_we    = nxt ? req_we[1] : req_we[0];
  assign sel_addr  = nxt ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign sel_wdata = nxt ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign sel_wstrb = nxt ? req_wstrb[2*SW-1:SW] : req_wstrb[SW-1:0];
  assign aw_done   = ~m_axi_awvalid | m_axi_awready;
  assign w_done    = ~m_axi_wvalid | m_axi_wready;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      addr          <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      ack           <= 2'b00;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: if (|req) begin
          grant       <= nxt;
          last_grant  <= nxt;
          addr        <= sel_addr & ~AW'(3);
          m_axi_wdata <= sel_wdata;
          m_axi_wstrb <= sel_wstrb;
          if (sel_we) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= WR_ADDR;
          end else begin
            m_axi_arvalid <= 1'b1;
            state         <= RD_ADDR;
          end
        end
        WR_ADDR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready) m_axi_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          rsp_resp     <= m_axi_bresp;
          ack[grant]   <= 1'b1;
          state        <= DONE;
        end
        RD_ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= RD_DATA;
        end
        RD_DATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          rsp_rdata    <= m_axi_rdata;
          rsp_resp     <= m_axi_rresp;
          ack[grant]   <= 1'b1;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb_axil_reg_arbiter: table vectors, randomized transactions against a register-file
// model, contention and mid-transaction reset sequences for axil_reg_arbiter.
module tb_axil_reg_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  req = '0, req_we = '0;
  logic [7:0]  req_addr = '0, req_wstrb = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  ack, rsp_resp, bresp, rresp;
  logic [31:0] rsp_rdata, wdata, rdata;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  int vectors = 0, miscompares = 0;

  axil_reg_arbiter dut (
    .ACLK(clk), .ARESETN(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .ack(ack), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready));

  // Slave model with programmable per-channel wait states and response code.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  slv_resp = 2'b00;
  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;
  int aw_c, w_c, b_c, ar_c, r_c, n_aw, n_w, n_b, n_ar, n_r;
  logic have_aw, have_w, r_pend;
  logic [3:0]  aw_a, ar_a, w_s;
  logic [31:0] w_d;
  logic [31:0] mem [4];
  assign awready = awvalid && aw_c >= aw_dly;
  assign wready  = wvalid && w_c >= w_dly;
  assign bvalid  = have_aw && have_w && b_c >= b_dly;
  assign arready = arvalid && ar_c >= ar_dly;
  assign rvalid  = r_pend && r_c >= r_dly;
  assign bresp   = slv_resp;
  assign rresp   = slv_resp;
  assign rdata   = force_en ? force_val : mem[ar_a[3:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {aw_c, w_c, b_c, ar_c, r_c} <= '0;
      {have_aw, have_w, r_pend} <= '0;
      {aw_a, ar_a, w_s, w_d} <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      {n_aw, n_w, n_b, n_ar, n_r} <= '0;
    end else begin
      aw_c <= (awvalid && !awready) ? aw_c + 1 : 0;
      w_c  <= (wvalid && !wready) ? w_c + 1 : 0;
      b_c  <= (have_aw && have_w && !(bvalid && bready)) ? b_c + 1 : 0;
      ar_c <= (arvalid && !arready) ? ar_c + 1 : 0;
      r_c  <= (r_pend && !(rvalid && rready)) ? r_c + 1 : 0;
      if (awvalid && awready) begin aw_a <= awaddr; have_aw <= 1'b1; n_aw <= n_aw + 1; end
      if (wvalid && wready) begin w_d <= wdata; w_s <= wstrb; have_w <= 1'b1; n_w <= n_w + 1; end
      if (bvalid && bready) begin
        for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_a[3:2]][8*i +: 8] <= w_d[8*i +: 8];
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        n_b     <= n_b + 1;
      end
      if (arvalid && arready) begin ar_a <= araddr; r_pend <= 1'b1; n_ar <= n_ar + 1; end
      if (rvalid && rready) begin r_pend <= 1'b0; n_r <= n_r + 1; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (|ack) chk("ack_onehot", 32'($countones(ack)), 32'd1);
    if (awvalid || arvalid) chk("prot_zero", {26'd0, awprot, arprot}, 32'd0);
  end

  typedef struct {
    logic r; logic we; logic [3:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    int aw; int w; int b; int ar; int rd; logic [1:0] resp; logic fe; logic [31:0] fv;
    logic [3:0] exp_addr; logic [31:0] exp_rdata; logic [1:0] exp_resp; int exp_lat;
  } vec_t;

  logic [31:0] mdl [4];
  logic [31:0] last_rd;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  task automatic do_txn(input vec_t v, output logic [31:0] rd, output logic [1:0] rs, output int lat);
    int b_aw, b_w, b_b, b_ar, b_r;
    @(negedge clk);
    {b_aw, b_w, b_b, b_ar, b_r} = {n_aw, n_w, n_b, n_ar, n_r};
    {aw_dly, w_dly, b_dly, ar_dly, r_dly} = {v.aw, v.w, v.b, v.ar, v.rd};
    slv_resp = v.resp; force_en = v.fe; force_val = v.fv;
    req_we[v.r] = v.we;
    req_addr[v.r*4 +: 4] = v.addr;
    req_wdata[v.r*32 +: 32] = v.wdata;
    req_wstrb[v.r*4 +: 4] = v.wstrb;
    req[v.r] = 1'b1;
    lat = 1;
    while (!ack[v.r] && lat < 100) begin @(negedge clk); lat++; end
    rd = rsp_rdata; rs = rsp_resp;
    req[v.r] = 1'b0;
    chk("ack_bit", {30'd0, ack}, v.r ? 32'd2 : 32'd1);
    if (v.we) begin
      chk("aw_hs_count", n_aw - b_aw, 1);
      chk("w_hs_count", n_w - b_w, 1);
      chk("b_hs_count", n_b - b_b, 1);
      chk("awaddr", {28'd0, aw_a}, {28'd0, v.exp_addr});
      chk("wdata", w_d, v.wdata);
      chk("wstrb", {28'd0, w_s}, {28'd0, v.wstrb});
    end else begin
      chk("ar_hs_count", n_ar - b_ar, 1);
      chk("r_hs_count", n_r - b_r, 1);
      chk("araddr", {28'd0, ar_a}, {28'd0, v.exp_addr});
    end
  endtask

  vec_t tbl [18];
  initial begin
    vec_t v;
    logic [31:0] rd;
    logic [1:0] rs;
    int lat, k, c, m;
    tbl[0]  = '{1'b0, 1'b1, 4'h4, 32'h2,        4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h4, 32'h0, 2'b00, 4};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 32'h1,        4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h0, 32'h0, 2'b00, 4};
    tbl[2]  = '{1'b1, 1'b1, 4'h4, 32'h2,        4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h4, 32'h0, 2'b00, 4};
    tbl[3]  = '{1'b1, 1'b1, 4'h8, 32'h3,        4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h8, 32'h0, 2'b00, 4};
    tbl[4]  = '{1'b1, 1'b1, 4'hC, 32'h4,        4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'hC, 32'h0, 2'b00, 4};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h0, 32'h1, 2'b00, 4};
    tbl[6]  = '{1'b1, 1'b0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h4, 32'h2, 2'b00, 4};
    tbl[7]  = '{1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h8, 32'h3, 2'b00, 4};
    tbl[8]  = '{1'b1, 1'b0, 4'hC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'hC, 32'h4, 2'b00, 4};
    tbl[9]  = '{1'b0, 1'b1, 4'h8, 32'hA5,       4'hF, 3, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h8, 32'h4, 2'b00, 7};
    tbl[10] = '{1'b1, 1'b1, 4'hC, 32'h5A,       4'hF, 0, 3, 2, 0, 0, 2'b00, 1'b0, 32'h0, 4'hC, 32'h4, 2'b00, 9};
    tbl[11] = '{1'b0, 1'b0, 4'h7, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b10, 1'b1, 32'hDEADBEEF, 4'h4, 32'hDEADBEEF, 2'b10, 4};
    tbl[12] = '{1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b11, 1'b0, 32'h0, 4'h8, 32'hA5, 2'b11, 7};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 4'h5, 0, 0, 0, 0, 0, 2'b01, 1'b0, 32'h0, 4'h0, 32'hA5, 2'b01, 4};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h0, 32'h00FF00FF, 2'b00, 4};
    tbl[15] = '{1'b1, 1'b0, 4'hD, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'hC, 32'h5A, 2'b00, 4};
    tbl[16] = '{1'b0, 1'b1, 4'h6, 32'h77,       4'h3, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h4, 32'h5A, 2'b00, 4};
    tbl[17] = '{1'b1, 1'b0, 4'h5, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4'h4, 32'h77, 2'b00, 4};
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    last_rd = '0;

    repeat (3) @(negedge clk);
    chk("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_resp", {30'd0, rsp_resp}, 32'd0);
    chk("rst_addr_data", {awaddr, araddr, wstrb, 20'd0}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    rst_n = 1'b1;

    // Both requesters held continuously: grants must alternate starting with r0.
    req_we = 2'b00; req_addr = 8'h40; req = 2'b11;
    k = 0; c = 0;
    while (k < 8 && c < 200) begin
      @(negedge clk); c++;
      if (|ack) begin
        chk("contention_grant", {30'd0, ack}, (k % 2) ? 32'd2 : 32'd1);
        k++;
        if (k == 8) req = 2'b00;
      end
    end
    chk("contention_acks", k, 8);
    req = 2'b00;

    for (int i = 0; i < 18; i++) begin
      do_txn(tbl[i], rd, rs, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_resp", i), {30'd0, rs}, {30'd0, tbl[i].exp_resp});
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      if (tbl[i].we) mdl[tbl[i].addr[3:2]] = merge(mdl[tbl[i].addr[3:2]], tbl[i].wdata, tbl[i].wstrb);
      last_rd = rd;
    end
    if (!tbl[11].fe) last_rd = '0;

    for (int i = 0; i < 60; i++) begin
      v.r = 1'($urandom); v.we = 1'($urandom); v.addr = 4'($urandom);
      v.wdata = $urandom; v.wstrb = 4'($urandom);
      v.aw = $urandom_range(0, 3); v.w = $urandom_range(0, 3); v.b = $urandom_range(0, 3);
      v.ar = $urandom_range(0, 3); v.rd = $urandom_range(0, 3);
      v.resp = 2'($urandom); v.fe = 1'b0; v.fv = '0;
      v.exp_addr = {v.addr[3:2], 2'b00};
      v.exp_rdata = v.we ? last_rd : mdl[v.addr[3:2]];
      v.exp_resp = v.resp;
      m = (v.aw > v.w) ? v.aw : v.w;
      v.exp_lat = v.we ? 4 + m + v.b : 4 + v.ar + v.rd;
      do_txn(v, rd, rs, lat);
      chk("rand_rdata", rd, v.exp_rdata);
      chk("rand_resp", {30'd0, rs}, {30'd0, v.exp_resp});
      chk("rand_lat", lat, v.exp_lat);
      if (v.we) mdl[v.addr[3:2]] = merge(mdl[v.addr[3:2]], v.wdata, v.wstrb);
      last_rd = v.exp_rdata;
    end

    // Reset while the write response is pending: no ack, and r0 wins afterwards.
    @(negedge clk);
    {aw_dly, w_dly, ar_dly, r_dly} = '0; b_dly = 20; force_en = 1'b0;
    req_we[0] = 1'b1; req_addr[3:0] = 4'h0; req_wdata[31:0] = 32'h1234; req_wstrb[3:0] = 4'hF;
    req[0] = 1'b1;
    c = 0;
    while (!bready && c < 50) begin @(negedge clk); c++; end
    chk("reach_wr_resp", {31'd0, bready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    req = 2'b00;
    repeat (3) begin @(negedge clk); chk("rst_no_ack", {30'd0, ack}, 32'd0); end
    b_dly = 0; rst_n = 1'b1;
    req_we = 2'b00; req_addr = 8'h40; req = 2'b11;
    c = 0;
    while (ack == 2'b00 && c < 50) begin @(negedge clk); c++; end
    chk("post_reset_first_grant", {30'd0, ack}, 32'd1);
    req = 2'b00;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axil_reg_arbiter.md
Name: axil_reg_arbiter

Overview:
- Shares one AXI4-Lite master port between two register-access requesters: a processor-side config path and a hardware sequencer.
- Drives the 4-register custom_demo_ip slave through that port.
- Each requester uses a simple hold-until-ack request interface. The block arbitrates round-robin and runs exactly one AXI4-Lite read or write at a time.
- Sits in the block design between the requesters and the slave's S00_AXI port.

Parameters:
- C_ADDR_WIDTH, 4, byte-address width of the slave register space (4 x 32-bit regs).
- C_DATA_WIDTH, 32, data width; fixed at 32, and the block supports only 32.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; one clock domain, reset is asynchronous and active-low
- req  in  2  per-requester request; held high until ack
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2*C_ADDR_WIDTH  byte address per requester; requester n uses slice n
- req_wdata  in  2*32  write data per requester
- req_wstrb  in  2*4  write strobes per requester
- ack  out  2  one-cycle completion pulse per requester
- rsp_rdata  out  32  read data; valid with ack
- rsp_resp  out  2  BRESP/RRESP of the completed access; valid with ack
- m_axi_awaddr  out  C_ADDR_WIDTH  write address
- m_axi_awprot  out  3  write protection
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  write strobes
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  C_ADDR_WIDTH  read address
- m_axi_arprot  out  3  read protection
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=1 so requester 0 wins first.
  - All valid/ready/ack outputs low; addr/data/rsp registers 0.
  - Reset mid-transaction abandons it with no ack; the requester must re-request.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req bit is high, pick the grant: the single requester if only one; if both, the one != last_grant.
  - Latch grant, we, addr (bits [1:0] forced to 0), wdata and wstrb into registers.
  - Update last_grant, then go to WR_ADDR or RD_ADDR.
  - The AXI valid signals rise the cycle after req is sampled.
- WR_ADDR:
  - awvalid and wvalid assert together and are tracked independently.
  - Each valid drops the cycle after its own handshake (valid & ready).
  - Leave for WR_RESP once both handshakes are done, in either order or the same cycle.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp and go to DONE.
- RD_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp and go to DONE.
- DONE:
  - ack[grant] high for exactly one cycle; rsp_rdata and rsp_resp hold until the next DONE.
  - Rsp_rdata is left unchanged after a write.
  - Next state is IDLE.
- Requester protocol:
  - Fields must stay stable while req is high.
  - Req must drop the cycle after ack. If it stays high, it is a new request, arbitrated at lowest priority.
- Latency with a zero-wait slave: req to ack = 4 cycles (IDLE, addr, resp/data, DONE).
- Protection and errors:
  - awprot and arprot are always 3'b000.
  - SLVERR/DECERR pass through unchanged on rsp_resp; no retry.
- Only one outstanding AXI transaction ever. A req arriving during a transaction waits; no request is dropped.

Test Plan:
- Single write: r0 writes addr 0x4 data 0x00000002 strb 0xF with awready/wready/bvalid immediate -> awaddr=0x4 and wdata=0x2 seen; ack[0] pulses 4 cycles after req; rsp_resp=00.
- Write/read-back: r1 writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads each back -> rsp_rdata matches each value; ack only ever on bit 1.
- Contention: req=2'b11 held continuously from just after reset -> grants alternate r0, r1, r0, r1; neither starves; ack never on both bits at once.
- Split handshakes: wready 3 cycles before awready, then the reverse order -> each valid drops after its own handshake; exactly one B phase; single ack.
- Error and unaligned address: read from 0x7 with slave returning rresp=2'b10, rdata 0xDEADBEEF -> araddr=0x4; rsp_resp=10; rsp_rdata=0xDEADBEEF.
- Reset in WR_RESP: deassert ARESETN while bvalid is pending -> outputs low asynchronously; no ack; after release, r0 wins the first grant.
